stream_demux_1to5: RTL and testbench
====================================

Name: stream_demux_1to5

Overview:
- Write-side counterpart of the processor's 5:1 operand/result select path: takes one DATA_WIDTH stream tagged with a 3-bit destination select and delivers each word to exactly one of five consumers.
- Decouples producer and consumers through a 2-entry FIFO with a valid/ready handshake on both sides.
- Selects 5..7 are illegal: each such word is accepted, then dropped, flagged and counted.
- Sits between the writeback/result stage and the five destination units (register file port, memory write, I/O, etc.).

Parameters:
- DATA_WIDTH, 16, width of the data word.
- SEL_WIDTH, 3, width of the destination select.
- NUM_OUT, 5, number of legal destinations (legal selects 0..NUM_OUT-1).
- ERR_CNT_WIDTH, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  word to deliver.
- in_sel  in  SEL_WIDTH  destination index.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- out_data  out  DATA_WIDTH  head word, shared bus to all destinations.
- out_valid  out  NUM_OUT  one-hot; bit k set means the head word is for destination k.
- out_ready  in  NUM_OUT  per-destination ready.
- sel_err  out  1  one-cycle pulse: an illegal-select word was dropped.
- err_count  out  ERR_CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FIFO emptied, count=0, rd/wr pointers=0.
  - out_valid=0, out_data=0, sel_err=0, err_count=0.
  - in_ready=0 while reset_n=0, then 1 from the first clock after release.
- Input accept: a transfer occurs when in_valid && in_ready. in_ready = (count < 2); it depends only on registered state, never on out_ready.
- Legal select (in_sel < NUM_OUT):
  - Write {in_sel, in_data} at wr_ptr; wr_ptr toggles.
  - count increments unless a pop occurs in the same cycle.
- Illegal select (in_sel >= NUM_OUT):
  - Word is consumed (handshake completes) but not written to the FIFO.
  - sel_err=1 in the following cycle only.
  - err_count increments and saturates at 2^ERR_CNT_WIDTH-1.
  - Consecutive illegal words give consecutive sel_err pulses.
- Output:
  - When count>0: out_data = head data; out_valid = one-hot of head sel.
  - When count=0: out_valid=0 and out_data holds its last value (0 after reset).
- Output transfer (pop): happens when out_valid[k] && out_ready[k] for head sel k. rd_ptr toggles; count decrements. out_ready bits for other destinations are ignored.
- Latency: a word accepted at edge N is visible on out_valid after edge N; there is no combinational in->out pass-through. Throughput is one word per cycle when the consumer is always ready.
- Simultaneous events:
  - Push + pop at count=1: count stays 1 and the new word becomes head after the edge.
  - Push + pop at count=0: impossible (no head).
  - At count=2, in_ready=0, so no push; a pop that cycle makes in_ready=1 next cycle.
  - Illegal word + pop: the pop proceeds normally and count decrements.
- Head stability: while out_valid is set and its out_ready is low, out_data and out_valid must not change (AXI-style hold).
- Pointer wrap: 1-bit pointers; full and empty are distinguished by count (0..2).
- Reset mid-operation: all contents discarded immediately; no partial delivery after release.
- Internal state: no FSM beyond count ∈ {EMPTY=0, ONE=1, FULL=2}. Transitions: push only +1, pop only −1, both 0.

Decomposition:
- Shared package processor_pkg holds:
  - DEST_REGFILE=0, DEST_MEM=1, DEST_IO=2, DEST_PC=3, DEST_AUX=4 destination constants.
  - typedef for the {sel,data} FIFO entry.
  - ERR_CNT_WIDTH default.
- One natural sub-module: fifo2 (parameterised 2-entry FIFO with push/pop/count), reusable elsewhere. The demux decode, error logic and counter stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=5'b00000, err_count=0; after release in_ready=1 on the next cycle.
- Streaming: send 0x1111 (sel 0), 0x2222 (sel 4), 0x3333 (sel 2) back-to-back with out_ready=5'b11111 → out_valid shows 00001, 10000, 00100 on consecutive cycles starting one cycle after the first accept, with data matching.
- Backpressure/full: out_ready=0; send sel 1 0xAAAA, sel 3 0xBBBB, then a third word → third word stalls (in_ready=0); head 0xAAAA with out_valid=00010 is stable. Raise out_ready[1] → pop, in_ready=1 next cycle, then 0xBBBB with out_valid=01000.
- Wrong-destination ready: head for sel 2, out_ready=5'b11011 → no pop for 10 cycles; set out_ready[2] → pop.
- Illegal select: send sel 5, 6, 7 with data 0xDEAD → three consecutive sel_err pulses, err_count=3, out_valid stays 0. Then send 256 illegal words → err_count saturates at 255.
- Mid-operation reset: FIFO full, assert reset_n=0 asynchronously between edges → out_valid=0 immediately. After release, no stale word appears.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared destination codes and FIFO entry layout for the result write path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package processor_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_SEL_WIDTH     = 3;
    localparam int DEF_NUM_OUT       = 5;
    localparam int DEF_ERR_CNT_WIDTH = 8;

    // Destination unit indices carried on the select field.
    localparam logic [DEF_SEL_WIDTH-1:0] DEST_REGFILE = 3'd0;
    localparam logic [DEF_SEL_WIDTH-1:0] DEST_MEM     = 3'd1;
    localparam logic [DEF_SEL_WIDTH-1:0] DEST_IO      = 3'd2;
    localparam logic [DEF_SEL_WIDTH-1:0] DEST_PC      = 3'd3;
    localparam logic [DEF_SEL_WIDTH-1:0] DEST_AUX     = 3'd4;

    // One queued word: destination select above the payload.
    typedef struct packed {
        logic [DEF_SEL_WIDTH-1:0]  sel;
        logic [DEF_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fifo2.sv
// Two-entry FIFO with explicit push/pop and an occupancy count (0..2).
// Latency: a pushed entry is visible at head_data after the next rising edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fifo2 #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, 1-bit pointers and occupancy; full vs empty is told apart by count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/stream_demux_1to5.sv
// Routes one select-tagged stream to one of NUM_OUT consumers; illegal selects are dropped and counted.
// Latency: one cycle from input accept to out_valid; no combinational input-to-output path.
// Backpressure: in_ready depends only on FIFO occupancy; head holds until its own destination is ready.
module stream_demux_1to5
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH     = DEF_SEL_WIDTH,
    parameter int NUM_OUT       = DEF_NUM_OUT,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [SEL_WIDTH-1:0]     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic                     sel_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef struct packed {
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [SEL_WIDTH-1:0] LAST_LEGAL = SEL_WIDTH'(NUM_OUT - 1);

    logic                  ready_en;
    logic [1:0]            count;
    logic                  has_head;
    entry_t                wr_entry;
    entry_t                head;
    logic                  accept;
    logic                  illegal;
    logic                  push;
    logic                  pop;
    logic [NUM_OUT-1:0]    head_onehot;
    logic [DATA_WIDTH-1:0] last_data;

    // Hold in_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready = ready_en && (count != 2'd2);
    assign accept   = in_valid && in_ready;
    assign illegal  = accept && (in_sel > LAST_LEGAL);
    assign push     = accept && !illegal;
    assign wr_entry = '{sel: in_sel, data: in_data};
    assign has_head = (count != 2'd0);

    fifo2 #(
        .WIDTH (SEL_WIDTH + DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    // Decode the head select to a one-hot valid; nothing is offered when empty.
    always_comb begin
        head_onehot = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            head_onehot[k] = has_head && (head.sel == SEL_WIDTH'(k));
        end
    end

    // Only the addressed destination's ready can retire the head.
    assign pop       = |(head_onehot & out_ready);
    assign out_valid = head_onehot;
    assign out_data  = has_head ? head.data : last_data;

    // Remember the most recent head so out_data holds steady once the FIFO drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_data <= '0;
        end else if (has_head) begin
            last_data <= head.data;
        end
    end

    // One-cycle drop pulse per illegal word, plus a saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err   <= 1'b0;
            err_count <= '0;
        end else begin
            sel_err <= illegal;
            if (illegal && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1to5.sv
module tb_stream_demux_1to5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic        sel_err;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of pending words plus a few scalars.
    logic [2:0]  q_sel[$];
    logic [15:0] q_dat[$];
    logic        m_ready_en;
    logic [15:0] m_last;
    logic        m_sel_err;
    int          m_err;

    always #5 clk = ~clk;

    stream_demux_1to5 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic drive(logic v, logic [2:0] s, logic [15:0] d, logic [4:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        logic [4:0]  e_valid;
        logic [15:0] e_data;
        logic        e_ready;
        logic        acc;
        logic        popm;
        @(negedge clk);
        if (!reset_n) begin
            q_sel.delete();
            q_dat.delete();
            m_ready_en = 1'b0;
            m_last     = 16'h0;
            m_sel_err  = 1'b0;
            m_err      = 0;
        end
        e_valid = (q_sel.size() > 0) ? (5'b00001 << q_sel[0]) : 5'b00000;
        e_data  = (q_dat.size() > 0) ? q_dat[0] : m_last;
        e_ready = m_ready_en && (q_sel.size() < 2);
        chk("in_ready",  {31'b0, in_ready},  {31'b0, e_ready});
        chk("out_valid", {27'b0, out_valid}, {27'b0, e_valid});
        chk("out_data",  {16'b0, out_data},  {16'b0, e_data});
        chk("sel_err",   {31'b0, sel_err},   {31'b0, m_sel_err});
        chk("err_count", {24'b0, err_count}, 32'(m_err));
        if (reset_n) begin
            acc  = in_valid && e_ready;
            popm = (q_sel.size() > 0) && out_ready[q_sel[0]];
            if (popm) begin
                m_last = q_dat[0];
                void'(q_sel.pop_front());
                void'(q_dat.pop_front());
            end
            m_sel_err = 1'b0;
            if (acc) begin
                if (in_sel < 3'd5) begin
                    q_sel.push_back(in_sel);
                    q_dat.push_back(in_data);
                end else begin
                    m_sel_err = 1'b1;
                    if (m_err < 255) m_err++;
                end
            end
            m_ready_en = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 3'd0, 16'h1234, 5'b00000);

        // Reset held for three cycles with a word offered.
        repeat (3) step();
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
        chk("rst_out_valid", {27'b0, out_valid}, 32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        reset_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back streaming to sel 0, 4, 2 with every consumer ready.
        drive(1'b1, 3'd0, 16'h1111, 5'b11111); step();
        chk("stream0_valid", {27'b0, out_valid}, 32'h01);
        chk("stream0_data",  {16'b0, out_data},  32'h1111);
        drive(1'b1, 3'd4, 16'h2222, 5'b11111); step();
        chk("stream1_valid", {27'b0, out_valid}, 32'h10);
        chk("stream1_data",  {16'b0, out_data},  32'h2222);
        drive(1'b1, 3'd2, 16'h3333, 5'b11111); step();
        chk("stream2_valid", {27'b0, out_valid}, 32'h04);
        chk("stream2_data",  {16'b0, out_data},  32'h3333);
        in_valid = 1'b0; step();
        chk("drain_valid", {27'b0, out_valid}, 32'h00);
        chk("drain_hold",  {16'b0, out_data},  32'h3333);

        // Fill to two entries, stall a third word, then release destination 1.
        drive(1'b1, 3'd1, 16'hAAAA, 5'b00000); step();
        drive(1'b1, 3'd3, 16'hBBBB, 5'b00000); step();
        drive(1'b1, 3'd0, 16'hCCCC, 5'b00000); step();
        chk("full_in_ready", {31'b0, in_ready},  32'd0);
        chk("full_valid",    {27'b0, out_valid}, 32'h02);
        repeat (3) step();
        chk("full_hold_data", {16'b0, out_data}, 32'hAAAA);
        out_ready = 5'b00010; step();
        chk("pop_in_ready", {31'b0, in_ready},  32'd1);
        chk("pop_valid",    {27'b0, out_valid}, 32'h08);
        chk("pop_data",     {16'b0, out_data},  32'hBBBB);
        step();
        drive(1'b0, 3'd0, 16'h0000, 5'b11111);
        repeat (3) step();

        // Ready asserted only on destinations other than the head's.
        drive(1'b1, 3'd2, 16'h5555, 5'b00000); step();
        drive(1'b0, 3'd0, 16'h0000, 5'b11011);
        repeat (10) step();
        chk("wrong_rdy_valid", {27'b0, out_valid}, 32'h04);
        chk("wrong_rdy_data",  {16'b0, out_data},  32'h5555);
        out_ready = 5'b00100; step();
        chk("right_rdy_valid", {27'b0, out_valid}, 32'h00);

        // Illegal selects: three consecutive pulses, then saturation.
        drive(1'b1, 3'd5, 16'hDEAD, 5'b11111); step();
        chk("ill_pulse1", {31'b0, sel_err}, 32'd1);
        in_sel = 3'd6; step();
        in_sel = 3'd7; step();
        chk("ill_pulse3", {31'b0, sel_err},   32'd1);
        chk("ill_count3", {24'b0, err_count}, 32'd3);
        in_valid = 1'b0; step();
        chk("ill_pulse_end", {31'b0, sel_err},   32'd0);
        chk("ill_no_valid",  {27'b0, out_valid}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 3'($urandom_range(5, 7)), 16'($urandom), 5'b11111);
            step();
        end
        in_valid = 1'b0; step();
        chk("ill_saturate", {24'b0, err_count}, 32'd255);

        // Asynchronous reset with the FIFO full.
        drive(1'b1, 3'd1, 16'h7777, 5'b00000); step();
        in_sel = 3'd4; in_data = 16'h8888; step();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {27'b0, out_valid}, 32'd0);
        chk("async_rst_ready", {31'b0, in_ready},  32'd0);
        step();
        reset_n = 1'b1;
        out_ready = 5'b11111;
        repeat (3) step();
        chk("post_rst_valid", {27'b0, out_valid}, 32'd0);
        chk("post_rst_count", {24'b0, err_count}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                  16'($urandom), 5'($urandom));
            step();
        end
        reset_n = 1'b1;
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
